// File: rtl/dice_roller_multi_if.sv
// Dice front-panel bundle: button in, 7-segment scan and locked-result bus out.
// master = the dice block, slave = whoever drives the button and reads the display.
interface dice_roller_multi_if #(
    parameter int NUM_DICE = 2
);
    logic                    btn_n;
    logic [6:0]              seg;
    logic [NUM_DICE-1:0]     dig_en;
    logic [4*NUM_DICE-1:0]   value_bus;
    logic                    result_valid;
    logic                    rolling;

    modport master (
        input  btn_n,
        output seg, dig_en, value_bus, result_valid, rolling
    );

    modport slave (
        output btn_n,
        input  seg, dig_en, value_bus, result_valid, rolling
    );
endinterface

// File: rtl/dice_roller_multi.sv
// N-die electronic dice: shared Galois LFSR, rejection-sampled scramble, debounced
// lock button with timed hold, and a multiplexed common-cathode 7-segment display.
module dice_roller_multi #(
    parameter int CLK_HZ      = 27000000,
    parameter int NUM_DICE    = 2,
    parameter int FACES       = 6,
    parameter int ROLL_HZ     = 200,
    parameter int HOLD_MS     = 5000,
    parameter int DEBOUNCE_MS = 10,
    parameter int SCAN_HZ     = 1000
) (
    input  logic                clk,
    input  logic                rst,
    dice_roller_multi_if.master bus
);
    localparam int TICK_R = CLK_HZ / ROLL_HZ;
    localparam int DEB_R  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int HOLD_R = CLK_HZ / 1000 * HOLD_MS;
    localparam int SCAN_R = CLK_HZ / SCAN_HZ;
    localparam int TICK   = (TICK_R < 1) ? 1 : TICK_R;
    localparam int DEB    = (DEB_R  < 1) ? 1 : DEB_R;
    localparam int HOLD   = (HOLD_R < 1) ? 1 : HOLD_R;
    localparam int SCAN   = (SCAN_R < 1) ? 1 : SCAN_R;

    localparam int TW  = $clog2(TICK + 1);
    localparam int DBW = $clog2(DEB + 1);
    localparam int HW  = $clog2(HOLD + 1);
    localparam int SW  = $clog2(SCAN + 1);
    localparam int DW  = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;

    localparam logic [TW-1:0]  TICK_MAX = TW'(TICK - 1);
    localparam logic [DBW-1:0] DEB_MAX  = DBW'(DEB - 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD - 1);
    localparam logic [SW-1:0]  SCAN_MAX = SW'(SCAN - 1);
    localparam logic [DW-1:0]  DIG_MAX  = DW'(NUM_DICE - 1);
    localparam logic [3:0]     FACES4   = 4'(FACES);

    typedef enum logic {ROLLING, HOLD_ST} state_t;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    logic [15:0]               lfsr;
    logic [TW-1:0]             tick_cnt;
    logic                      tick;
    logic                      sync1, sync2, deb_level;
    logic [DBW-1:0]            deb_cnt;
    logic                      press;
    state_t                    state;
    logic [HW-1:0]             hold_cnt;
    logic [NUM_DICE-1:0][3:0]  die;
    logic                      rolling_q, valid_q;
    logic [SW-1:0]             scan_cnt;
    logic                      scan_wrap;
    logic [DW-1:0]             dig_idx, dig_nxt;
    logic [NUM_DICE-1:0]       dig_en_q;
    logic [6:0]                seg_q;

    // Galois form, x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= 16'hACE1;
            tick_cnt <= '0;
        end else begin
            lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_MAX);

    // The counter only runs while the synchronised input disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            sync1 <= bus.btn_n;
            sync2 <= sync1;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_MAX) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press = deb_level && !sync2 && (deb_cnt == DEB_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ROLLING;
            rolling_q <= 1'b1;
            valid_q   <= 1'b0;
            hold_cnt  <= '0;
            die       <= {NUM_DICE{4'd1}};
        end else begin
            valid_q <= 1'b0;
            case (state)
                ROLLING: begin
                    // A press on a tick cycle wins: the tick's scramble is dropped.
                    if (press) begin
                        state     <= HOLD_ST;
                        rolling_q <= 1'b0;
                        valid_q   <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (tick) begin
                        for (int i = 0; i < NUM_DICE; i++) begin
                            if (lfsr[4*i +: 4] < FACES4)
                                die[i] <= lfsr[4*i +: 4] + 4'd1;
                        end
                    end
                end
                HOLD_ST: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_MAX) begin
                        state     <= ROLLING;
                        rolling_q <= 1'b1;
                    end
                end
                default: state <= ROLLING;
            endcase
        end
    end

    assign scan_wrap = (scan_cnt == SCAN_MAX);
    assign dig_nxt   = scan_wrap ? ((dig_idx == DIG_MAX) ? '0 : dig_idx + 1'b1) : dig_idx;

    // Digit enable and segments load on the same edge so a digit never shows its neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            dig_en_q <= NUM_DICE'(1);
            seg_q    <= 7'b0110000;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            dig_idx  <= dig_nxt;
            dig_en_q <= NUM_DICE'(1) << dig_nxt;
            seg_q    <= decode(die[dig_nxt]);
        end
    end

    assign bus.value_bus    = die;
    assign bus.result_valid = valid_q;
    assign bus.rolling      = rolling_q;
    assign bus.dig_en       = dig_en_q;
    assign bus.seg          = seg_q;
endmodule

// File: tb/tb_dice_roller_multi.sv
// Directed bench for dice_roller_multi: a cycle model of LFSR/tick/scramble/hold/scan
// runs beside the DUT and locked results go through a scoreboard queue.
module tb_dice_roller_multi;
    localparam int TICK = 10;
    localparam int HOLD = 50;
    localparam int SCAN = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dice_roller_multi_if #(.NUM_DICE(2)) bus  ();
    dice_roller_multi_if #(.NUM_DICE(2)) bus9 ();

    dice_roller_multi #(
        .CLK_HZ(1000), .NUM_DICE(2), .FACES(6), .ROLL_HZ(100),
        .HOLD_MS(50), .DEBOUNCE_MS(3), .SCAN_HZ(250)
    ) dut (.clk(clk), .rst(rst), .bus(bus.master));

    dice_roller_multi #(
        .CLK_HZ(1000), .NUM_DICE(2), .FACES(9), .ROLL_HZ(100),
        .HOLD_MS(50), .DEBOUNCE_MS(3), .SCAN_HZ(250)
    ) dut9 (.clk(clk), .rst(rst), .bus(bus9.master));

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] t [0:15];
        for (int k = 0; k < 16; k++) t[k] = 7'b0000000;
        t[1] = 7'b0110000; t[2] = 7'b1101101; t[3] = 7'b1111001;
        t[4] = 7'b0110011; t[5] = 7'b1011011; t[6] = 7'b1011111;
        t[7] = 7'b1110000; t[8] = 7'b1111111; t[9] = 7'b1111011;
        return t[v];
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference model; press_at is the cycle index at which the bench expects a press.
    logic [15:0]      m_lfsr;
    int               m_tick, m_hold, m_scan, m_dig, cyc;
    logic [1:0][3:0]  m_die;
    logic             m_rolling, m_rv;
    logic [6:0]       m_seg;
    int               press_at = -1;
    logic [7:0]       exp_q [$];

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr <= 16'hACE1; m_tick <= 0; m_hold <= 0; m_scan <= 0; m_dig <= 0;
            m_die <= {4'd1, 4'd1}; m_rolling <= 1'b1; m_rv <= 1'b0; m_seg <= dec(4'd1);
            cyc <= 0;
        end else begin
            cyc    <= cyc + 1;
            m_lfsr <= lfsr_step(m_lfsr);
            m_tick <= (m_tick == TICK - 1) ? 0 : m_tick + 1;
            m_rv   <= 1'b0;
            if (m_rolling) begin
                if (cyc == press_at) begin
                    m_rolling <= 1'b0; m_hold <= 0; m_rv <= 1'b1;
                    exp_q.push_back(m_die);
                end else if (m_tick == TICK - 1) begin
                    for (int d = 0; d < 2; d++)
                        if (m_lfsr[4*d +: 4] < 4'd6) m_die[d] <= m_lfsr[4*d +: 4] + 4'd1;
                end
            end else begin
                m_hold <= m_hold + 1;
                if (m_hold == HOLD - 1) m_rolling <= 1'b1;
            end
            if (m_scan == SCAN - 1) begin
                m_scan <= 0; m_dig <= (m_dig + 1) % 2; m_seg <= dec(m_die[(m_dig + 1) % 2]);
            end else begin
                m_scan <= m_scan + 1; m_seg <= dec(m_die[m_dig]);
            end
        end
    end

    logic       chk_en = 1'b0, gather = 1'b0, prev_rst = 1'b1;
    logic [5:0] seen0 = '0, seen1 = '0;
    logic [2:0] seen789 = '0;
    logic [7:0] prev_vb9;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("value_bus", bus.value_bus, m_die);
            chk("rolling", bus.rolling, m_rolling);
            chk("result_valid", bus.result_valid, m_rv);
            chk("dig_en", bus.dig_en, 2'b01 << m_dig);
            chk("seg", bus.seg, m_seg);
            chk("lfsr", dut.lfsr, m_lfsr);
            for (int d = 0; d < 2; d++) begin
                chk("range6", (bus.value_bus[4*d +: 4] >= 1 && bus.value_bus[4*d +: 4] <= 6), 1);
                chk("range9", (bus9.value_bus[4*d +: 4] >= 1 && bus9.value_bus[4*d +: 4] <= 9), 1);
            end
            if (bus.result_valid === 1'b1) begin
                if (exp_q.size() > 0) chk("sb_locked", bus.value_bus, exp_q.pop_front());
                else chk("sb_underflow", bus.result_valid, 1'b0);
            end
            if (gather) begin
                seen0 <= seen0 | (6'b1 << (bus.value_bus[3:0] - 1));
                seen1 <= seen1 | (6'b1 << (bus.value_bus[7:4] - 1));
            end
            if (!prev_rst) begin
                automatic logic [3:0] nib = prev_vb9[4*bus9.dig_en[1] +: 4];
                chk("dig9_onehot", (bus9.dig_en == 2'b01 || bus9.dig_en == 2'b10), 1);
                chk("seg9", bus9.seg, dec(nib));
                if (bus9.seg === dec(nib) && nib >= 7 && nib <= 9)
                    seen789 <= seen789 | (3'b1 << (nib - 7));
            end
        end
        prev_vb9 <= bus9.value_bus;
        prev_rst <= rst;
    end

    task automatic do_press(input bit on_tick, input bit disp35, input int second_at, input int rst_at,
                            output int lat, output int hlen, output logic [7:0] vb_pre, output logic [7:0] vb_frz);
        int guard = 0;
        if (on_tick) begin
            do begin @(posedge clk); #1; guard++; end while (m_tick != 5 && guard < 50);
        end else begin
            @(posedge clk); #1;
        end
        // two synchroniser flops plus three debounce cycles: freeze lands on the fifth edge
        bus.btn_n = 1'b0;
        press_at  = cyc + 4;
        vb_pre    = bus.value_bus;
        lat       = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.rolling === 1'b0) break;
            vb_pre = bus.value_bus;
        end
        press_at = -1;
        vb_frz   = bus.value_bus;
        hlen     = 0;
        while (bus.rolling === 1'b0 && hlen < 200) begin
            hlen++;
            chk("hold_frozen", bus.value_bus, vb_frz);
            if (disp35 && hlen <= 16)
                chk("seg_35", bus.seg, (bus.dig_en == 2'b01) ? 7'b1111001 : 7'b1011011);
            if (hlen == 15) bus.btn_n = 1'b1;
            if (hlen == second_at) bus.btn_n = 1'b0;
            if (hlen == second_at + 10) bus.btn_n = 1'b1;
            if (hlen == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_rolling", bus.rolling, 1'b1);
                chk("rst_value", bus.value_bus, 8'h11);
                chk("rst_valid", bus.result_valid, 1'b0);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.btn_n = 1'b1;
    endtask

    initial begin
        int lat, hlen, found;
        logic [7:0] pre, frz;
        rst = 1'b1; bus.btn_n = 1'b1; bus9.btn_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("reset_value", bus.value_bus, 8'h11);
        chk("reset_rolling", bus.rolling, 1'b1);
        chk("reset_dig_en", bus.dig_en, 2'b01);
        chk("reset_seg", bus.seg, 7'b0110000);
        chk("reset_valid", bus.result_valid, 1'b0);

        // LFSR bit-exact run, then long free run collecting face coverage
        repeat (100) @(negedge clk);
        gather = 1'b1;
        repeat (2000) @(negedge clk);
        gather = 1'b0;
        chk("faces_die0", seen0, 6'h3F);
        chk("faces_die1", seen1, 6'h3F);

        // clean press held 20 cycles
        do_press(1'b0, 1'b0, -100, -100, lat, hlen, pre, frz);
        chk("press_latency", lat, 6);
        chk("hold_len", hlen, HOLD);
        chk("freeze_val", frz, pre);
        repeat (10) @(negedge clk);

        // bounce pulses of 1 and 2 cycles while rolling
        @(posedge clk); #1 bus.btn_n = 1'b0;
        @(posedge clk); #1 bus.btn_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 bus.btn_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.btn_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_rolling", bus.rolling, 1'b1);

        // second press during hold must not stretch it
        do_press(1'b0, 1'b0, 20, -100, lat, hlen, pre, frz);
        chk("hold_len_2nd", hlen, HOLD);
        repeat (10) @(negedge clk);

        // press coinciding with a tick, then reset in mid-hold
        do_press(1'b1, 1'b0, -100, 25, lat, hlen, pre, frz);
        chk("tick_freeze", frz, pre);
        chk("rst_hold_len", hlen, 25);
        repeat (10) @(negedge clk);

        // lock on dice 3 and 5 and watch the scan
        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            @(negedge clk);
            if (bus.value_bus == 8'h53 && bus.rolling === 1'b1) found = 1;
        end
        chk("find_53", found, 1);
        do_press(1'b0, 1'b1, -100, -100, lat, hlen, pre, frz);
        chk("frozen_53", frz, 8'h53);
        chk("decode_789", seen789, 3'b111);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete within the time limit");
        $fatal(1, "watchdog");
    end
endmodule
